// File: rtl/frame_buffer_rotator_if.sv
// frame_buffer_rotator_if: vsync inputs and buffer-index/address outputs of the frame rotator
interface frame_buffer_rotator_if #(
    parameter int NUM_READERS = 1,
    parameter int PORT_W      = 2,
    parameter int ADDR_W      = 32
);
    logic                          enable;
    logic                          wr_vsync;
    logic [NUM_READERS-1:0]        rd_vsync;
    logic [PORT_W-1:0]             wr_port;
    logic [ADDR_W-1:0]             wr_base;
    logic [NUM_READERS*PORT_W-1:0] rd_port;
    logic [NUM_READERS*ADDR_W-1:0] rd_base;
    logic [PORT_W-1:0]             latest_port;
    logic                          latest_valid;
    logic [15:0]                   dropped_count;
    logic [15:0]                   frame_count;

    modport master (
        output enable, wr_vsync, rd_vsync,
        input  wr_port, wr_base, rd_port, rd_base, latest_port, latest_valid, dropped_count, frame_count
    );

    modport slave (
        input  enable, wr_vsync, rd_vsync,
        output wr_port, wr_base, rd_port, rd_base, latest_port, latest_valid, dropped_count, frame_count
    );
endinterface

// File: rtl/frame_buffer_rotator.sv
// frame_buffer_rotator: N-buffer frame rotation between one writer and several readers
module frame_buffer_rotator #(
    parameter int              NUM_BUFFERS  = 3,
    parameter int              NUM_READERS  = 1,
    parameter int              PORT_W       = 2,
    parameter int              ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(32'h0009_6000)
) (
    input logic                   clk,
    input logic                   reset,
    frame_buffer_rotator_if.slave bus
);
    if (NUM_BUFFERS < NUM_READERS + 2) begin : g_bad_buffers
        $error("frame_buffer_rotator: NUM_BUFFERS must be >= NUM_READERS+2");
    end
    if ((1 << PORT_W) < NUM_BUFFERS) begin : g_bad_port_w
        $error("frame_buffer_rotator: PORT_W too narrow for NUM_BUFFERS");
    end

    logic [PORT_W-1:0]      wr_q, wr_d, lat_q;
    logic [PORT_W-1:0]      rd_q [NUM_READERS];
    logic [PORT_W-1:0]      rd_d [NUM_READERS];
    logic [ADDR_W-1:0]      wr_base_q;
    logic [ADDR_W-1:0]      rd_base_q [NUM_READERS];
    logic                   val_q, fetched_q, en_wr, any_fetch, drop;
    logic [15:0]            drop_q, frame_q;
    logic [NUM_BUFFERS-1:0] used;

    function automatic logic [ADDR_W-1:0] base_of(input logic [PORT_W-1:0] p);
        return BASE_ADDR + ADDR_W'(p) * FRAME_STRIDE;
    endfunction

    // Reader hand-off: a pulsing reader takes the latest completed buffer as it stood before this edge
    always_comb begin
        any_fetch = 1'b0;
        for (int i = 0; i < NUM_READERS; i++) begin
            rd_d[i] = rd_q[i];
            if (bus.enable && bus.rd_vsync[i] && val_q) begin
                rd_d[i]   = lat_q;
                any_fetch = 1'b1;
            end
        end
        en_wr = bus.enable && bus.wr_vsync;
        drop  = en_wr && val_q && !fetched_q && !any_fetch;
    end

    // Writer's next buffer: lowest index not being completed now and not held by any reader next cycle
    always_comb begin
        used = '0;
        wr_d = wr_q;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            used[b] = (wr_q == PORT_W'(b));
            for (int i = 0; i < NUM_READERS; i++) used[b] = used[b] | (rd_d[i] == PORT_W'(b));
        end
        for (int b = NUM_BUFFERS - 1; b >= 0; b--) if (!used[b]) wr_d = PORT_W'(b);
    end

    // Rotation state, base addresses and frame/drop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= '0;
            wr_base_q <= BASE_ADDR;
            lat_q     <= '0;
            val_q     <= 1'b0;
            fetched_q <= 1'b0;
            drop_q    <= '0;
            frame_q   <= '0;
            for (int i = 0; i < NUM_READERS; i++) begin
                rd_q[i]      <= PORT_W'(1);
                rd_base_q[i] <= BASE_ADDR + FRAME_STRIDE;
            end
        end else begin
            for (int i = 0; i < NUM_READERS; i++) begin
                rd_q[i]      <= rd_d[i];
                rd_base_q[i] <= base_of(rd_d[i]);
            end
            if (any_fetch) fetched_q <= 1'b1;
            if (en_wr) begin
                lat_q     <= wr_q;
                val_q     <= 1'b1;
                fetched_q <= 1'b0;
                frame_q   <= frame_q + 16'd1;
                wr_q      <= wr_d;
                wr_base_q <= base_of(wr_d);
                if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // The writer must never share a buffer with a reader or the latest completed frame
    always_ff @(posedge clk) begin
        if (!reset && val_q)
            for (int i = 0; i < NUM_READERS; i++) assert (wr_q != rd_q[i] && wr_q != lat_q);
    end

    assign bus.wr_port       = wr_q;
    assign bus.wr_base       = wr_base_q;
    assign bus.latest_port   = lat_q;
    assign bus.latest_valid  = val_q;
    assign bus.dropped_count = drop_q;
    assign bus.frame_count   = frame_q;

    for (genvar i = 0; i < NUM_READERS; i++) begin : g_rd
        assign bus.rd_port[i*PORT_W +: PORT_W] = rd_q[i];
        assign bus.rd_base[i*ADDR_W +: ADDR_W] = rd_base_q[i];
    end
endmodule

// File: tb/tb_frame_buffer_rotator.sv
// tb_frame_buffer_rotator: directed and randomized checks of the frame rotator against a reference model
module tb_frame_buffer_rotator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    frame_buffer_rotator_if #(.NUM_READERS(1), .PORT_W(2), .ADDR_W(32)) ia ();
    frame_buffer_rotator_if #(.NUM_READERS(2), .PORT_W(2), .ADDR_W(32)) ib ();

    frame_buffer_rotator dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    frame_buffer_rotator #(.NUM_BUFFERS(4), .NUM_READERS(2), .PORT_W(2), .ADDR_W(32)) dut_b (
        .clk(clk), .reset(reset), .bus(ib.slave));

    task automatic cyc_a(input logic en, input logic w, input logic r);
        ia.enable = en; ia.wr_vsync = w; ia.rd_vsync = r;
        @(posedge clk); #1;
        ia.enable = 1'b1; ia.wr_vsync = 1'b0; ia.rd_vsync = 1'b0;
    endtask

    task automatic cyc_b(input logic en, input logic w, input logic [1:0] r);
        ib.enable = en; ib.wr_vsync = w; ib.rd_vsync = r;
        @(posedge clk); #1;
        ib.enable = 1'b1; ib.wr_vsync = 1'b0; ib.rd_vsync = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n++; if (ia.wr_port !== 2'd0 || ia.wr_base !== 32'h0) begin fails++; $display("FAIL reset_wr got %0d/%h want 0/0", ia.wr_port, ia.wr_base); end
        n++; if (ia.rd_port !== 2'd1 || ia.rd_base !== 32'h0009_6000) begin fails++; $display("FAIL reset_rd got %0d/%h want 1/00096000", ia.rd_port, ia.rd_base); end
        n++; if (ia.latest_valid !== 1'b0 || ia.latest_port !== 2'd0) begin fails++; $display("FAIL reset_latest got %b/%0d want 0/0", ia.latest_valid, ia.latest_port); end
        n++; if (ia.dropped_count !== 16'd0 || ia.frame_count !== 16'd0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", ia.dropped_count, ia.frame_count); end
        n++; if (ib.rd_port !== 4'b0101 || ib.rd_base !== {2{32'h0009_6000}}) begin fails++; $display("FAIL reset_rd_b got %h/%h want 5/both 00096000", ib.rd_port, ib.rd_base); end
    endtask

    task automatic test_single();
        do_reset();
        cyc_a(1, 1, 0);
        n++; if (ia.latest_port !== 2'd0 || ia.latest_valid !== 1'b1) begin fails++; $display("FAIL single_latest got %0d/%b want 0/1", ia.latest_port, ia.latest_valid); end
        n++; if (ia.wr_port !== 2'd2 || ia.wr_base !== 32'h0012_C000) begin fails++; $display("FAIL single_wr got %0d/%h want 2/0012c000", ia.wr_port, ia.wr_base); end
        n++; if (ia.frame_count !== 16'd1) begin fails++; $display("FAIL single_frames got %0d want 1", ia.frame_count); end
        cyc_a(1, 0, 1);
        n++; if (ia.rd_port !== 2'd0 || ia.rd_base !== 32'h0) begin fails++; $display("FAIL single_rd got %0d/%h want 0/0", ia.rd_port, ia.rd_base); end
    endtask

    task automatic test_drop();
        do_reset();
        cyc_a(1, 0, 1);
        n++; if (ia.rd_port !== 2'd1) begin fails++; $display("FAIL drop_rd_invalid got %0d want 1", ia.rd_port); end
        cyc_a(1, 1, 0);
        n++; if (ia.wr_port !== 2'd2 || ia.latest_port !== 2'd0) begin fails++; $display("FAIL drop_first got %0d/%0d want 2/0", ia.wr_port, ia.latest_port); end
        cyc_a(1, 1, 0);
        n++; if (ia.latest_port !== 2'd2 || ia.wr_port !== 2'd0 || ia.dropped_count !== 16'd1) begin fails++; $display("FAIL drop_second got lat %0d wr %0d drop %0d want 2/0/1", ia.latest_port, ia.wr_port, ia.dropped_count); end
        cyc_a(1, 0, 1);
        n++; if (ia.rd_port !== 2'd2) begin fails++; $display("FAIL drop_fetch got %0d want 2", ia.rd_port); end
        cyc_a(1, 1, 0);
        n++; if (ia.dropped_count !== 16'd1 || ia.wr_port !== 2'd1 || ia.latest_port !== 2'd0) begin fails++; $display("FAIL drop_third got drop %0d wr %0d lat %0d want 1/1/0", ia.dropped_count, ia.wr_port, ia.latest_port); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cyc_a(1, 1, 0);
        cyc_a(1, 1, 1);
        n++; if (ia.rd_port !== 2'd0 || ia.latest_port !== 2'd2 || ia.wr_port !== 2'd1) begin fails++; $display("FAIL simul_ports got rd %0d lat %0d wr %0d want 0/2/1", ia.rd_port, ia.latest_port, ia.wr_port); end
        n++; if (ia.dropped_count !== 16'd0 || ia.frame_count !== 16'd2) begin fails++; $display("FAIL simul_counts got %0d/%0d want 0/2", ia.dropped_count, ia.frame_count); end
    endtask

    task automatic test_enable();
        do_reset();
        cyc_a(1, 1, 0);
        for (int k = 0; k < 5; k++) cyc_a(0, 1, 1);
        for (int k = 0; k < 5; k++) cyc_a(0, k[0], ~k[0]);
        n++; if (ia.wr_port !== 2'd2 || ia.rd_port !== 2'd1 || ia.latest_port !== 2'd0 || ia.frame_count !== 16'd1 || ia.dropped_count !== 16'd0) begin
            fails++; $display("FAIL enable_hold got wr %0d rd %0d lat %0d fr %0d dr %0d want 2/1/0/1/0", ia.wr_port, ia.rd_port, ia.latest_port, ia.frame_count, ia.dropped_count); end
        cyc_a(1, 1, 0);
        n++; if (ia.wr_port !== 2'd0 || ia.latest_port !== 2'd2 || ia.frame_count !== 16'd2 || ia.dropped_count !== 16'd1) begin
            fails++; $display("FAIL enable_resume got wr %0d lat %0d fr %0d dr %0d want 0/2/2/1", ia.wr_port, ia.latest_port, ia.frame_count, ia.dropped_count); end
    endtask

    task automatic test_shared();
        do_reset();
        cyc_b(1, 1, 2'b00);
        n++; if (ib.wr_port !== 2'd2 || ib.latest_port !== 2'd0) begin fails++; $display("FAIL shared_first got wr %0d lat %0d want 2/0", ib.wr_port, ib.latest_port); end
        cyc_b(1, 0, 2'b11);
        n++; if (ib.rd_port !== 4'b0000 || ib.rd_base !== 64'h0) begin fails++; $display("FAIL shared_rd got %h/%h want 0/0", ib.rd_port, ib.rd_base); end
        cyc_b(1, 1, 2'b00);
        n++; if (ib.wr_port === 2'd0 || ib.wr_port !== 2'd1 || ib.latest_port !== 2'd2) begin fails++; $display("FAIL shared_wr got wr %0d lat %0d want 1/2", ib.wr_port, ib.latest_port); end
    endtask

    task automatic test_random();
        logic [1:0] m_wr, m_lat, b_sel;
        logic [1:0] m_rd [2];
        logic [1:0] nrd [2];
        logic       val, fet, fetch, en, w;
        logic [1:0] r;
        int         drop, frame;
        logic [159:0] got, exp;
        do_reset();
        m_wr = 0; m_lat = 0; m_rd[0] = 1; m_rd[1] = 1; val = 0; fet = 0; drop = 0; frame = 0;
        for (int c = 0; c < 10000; c++) begin
            en = ($urandom % 8) != 0;
            w  = ($urandom % 3) == 0;
            r  = 2'(($urandom % 4 == 0) ? 1 : 0) | 2'(($urandom % 4 == 0) ? 2 : 0);
            cyc_b(en, w, r);
            if (en) begin
                fetch = 0;
                for (int i = 0; i < 2; i++) begin
                    nrd[i] = m_rd[i];
                    if (r[i] && val) begin nrd[i] = m_lat; fetch = 1; end
                end
                if (w) begin
                    if (val && !fet && !fetch && drop < 16'hFFFF) drop++;
                    b_sel = 0;
                    for (int b = 3; b >= 0; b--) if (2'(b) != m_wr && 2'(b) != nrd[0] && 2'(b) != nrd[1]) b_sel = 2'(b);
                    m_lat = m_wr; m_wr = b_sel; val = 1; fet = 0; frame = (frame + 1) % 65536;
                end else if (fetch) fet = 1;
                m_rd = nrd;
            end
            got = {ib.wr_port, ib.rd_port, ib.latest_port, ib.latest_valid, ib.dropped_count, ib.frame_count, ib.wr_base, ib.rd_base, 9'd0};
            exp = {m_wr, m_rd[1], m_rd[0], m_lat, val, 16'(drop), 16'(frame), 32'(m_wr) * 32'h0009_6000,
                   32'(m_rd[1]) * 32'h0009_6000, 32'(m_rd[0]) * 32'h0009_6000, 9'd0};
            n++; if (got !== exp) begin fails++; $display("FAIL random_state cycle %0d got %h want %h", c, got, exp); end
            if (ib.latest_valid === 1'b1) begin
                n++; if (ib.wr_port === ib.rd_port[1:0] || ib.wr_port === ib.rd_port[3:2] || ib.wr_port === ib.latest_port) begin
                    fails++; $display("FAIL random_invariant cycle %0d got wr %0d rd %h lat %0d want wr distinct", c, ib.wr_port, ib.rd_port, ib.latest_port); end
            end
        end
    endtask

    initial begin
        ia.enable = 1'b1; ia.wr_vsync = 1'b0; ia.rd_vsync = 1'b0;
        ib.enable = 1'b1; ib.wr_vsync = 1'b0; ib.rd_vsync = 2'b00;
        test_reset();
        test_single();
        test_drop();
        test_simultaneous();
        test_enable();
        test_shared();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
